// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART blocks: register offsets,
// STATUS bit positions, FSM state encodings and the default window base.
package mmio_uart_tx_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0400;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_ACTIVE = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_PARITY = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // A divisor below 2 cannot form a bit period, so it is raised to 2.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int p_WIDTH = 8,
  parameter int p_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [p_WIDTH-1:0]         din,
  input  logic                       pop,
  output logic [p_WIDTH-1:0]         dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(p_DEPTH):0]   count
);

  localparam int AW = $clog2(p_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(p_DEPTH);

  logic [p_WIDTH-1:0] mem [p_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register window: +0 TXDATA (write pushes a byte), +1 STATUS (write clears
// overflow), +2 DIV (clock cycles per bit).
// Optional macro MMIO_UART_TX_PARITY_EN inserts an even-parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | driving the start bit (low)
// DATA   | shifting 8 data bits out LSB first
// PARITY | driving the even-parity bit (optional build)
// STOP   | driving the stop bit (high), then chaining the next byte
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] p_BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          p_FIFO_DEPTH = 8,
  parameter logic [15:0] p_DIV_RESET  = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_en,
  output logic [15:0] o_rd_data,
  output logic        o_rd_sel,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int CW = $clog2(p_FIFO_DEPTH) + 1;

  logic [15:0]   offset;
  logic [1:0]    offs;
  logic          hit;
  logic          push_req;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [15:0]   div_q;
  logic          ovf;
  logic [15:0]   status_word;
  logic [15:0]   rd_next;

  logic [2:0]    state;
  logic [15:0]   bit_cnt;
  logic [15:0]   cur_div;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          bit_end;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          par;
`endif

  assign offset   = i_addr - p_BASE_ADDR;
  assign offs     = offset[1:0];
  assign hit      = (i_addr >= p_BASE_ADDR) && (offset < 16'd3);
  assign push_req = i_wr_en && hit && (offs == REG_TXDATA);
  assign bit_end  = (bit_cnt == cur_div - 16'd1);

  assign o_tx   = tx_q;
  assign o_busy = !fifo_empty || (state != ST_IDLE);

  sync_fifo #(
    .p_WIDTH (8),
    .p_DEPTH (p_FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_req),
    .din   (i_wr_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FIFO pops when idle with data waiting, or at the end of a stop bit.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_IDLE) pop = 1'b1;
      else if ((state == ST_STOP) && bit_end) pop = 1'b1;
    end
  end

  // STATUS snapshot built from current state, before this cycle's updates.
  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY]  = fifo_empty;
    status_word[STAT_FULL]   = fifo_full;
    status_word[STAT_ACTIVE] = (state != ST_IDLE);
    status_word[STAT_OVF]    = ovf;
`ifdef MMIO_UART_TX_PARITY_EN
    status_word[STAT_PARITY] = 1'b1;
`else
    status_word[STAT_PARITY] = 1'b0;
`endif
    status_word[15:8] = 8'(fifo_count);
  end

  // Read data mux; TXDATA and non-hit addresses read as zero.
  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (offs)
        REG_STATUS: rd_next = status_word;
        REG_DIV:    rd_next = div_q;
        default:    rd_next = '0;
      endcase
    end
  end

  // Register file writes and sticky overflow tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= p_DIV_RESET;
      ovf   <= 1'b0;
    end else begin
      if (i_wr_en && hit && (offs == REG_DIV)) div_q <= clamp_div(i_wr_data);
      if (i_wr_en && hit && (offs == REG_STATUS)) ovf <= 1'b0;
      else if (push_req && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  // Registered read port, one cycle of latency like data RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data <= '0;
      o_rd_sel  <= 1'b0;
    end else begin
      o_rd_data <= rd_next;
      o_rd_sel  <= hit;
    end
  end

  // Transmit FSM; the bit period is latched at each bit boundary so a DIV
  // write never stretches or truncates the bit in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      tx_q    <= 1'b1;
      bit_cnt <= '0;
      cur_div <= p_DIV_RESET;
      bit_idx <= '0;
      shift   <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift   <= fifo_dout;
`ifdef MMIO_UART_TX_PARITY_EN
            par     <= ^fifo_dout;
`endif
            cur_div <= div_q;
            bit_cnt <= '0;
            tx_q    <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            bit_cnt <= '0;
            cur_div <= div_q;
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            cur_div <= div_q;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              tx_q  <= par;
              state <= ST_PARITY;
`else
              tx_q  <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            cur_div <= div_q;
            tx_q    <= 1'b1;
            state   <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            cur_div <= div_q;
            if (!fifo_empty) begin
              shift <= fifo_dout;
`ifdef MMIO_UART_TX_PARITY_EN
              par   <= ^fifo_dout;
`endif
              tx_q  <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (default build, parity disabled).
module tb_mmio_uart_tx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_addr;
  logic [15:0] i_wr_data;
  logic        i_wr_en;
  logic [15:0] o_rd_data;
  logic        o_rd_sel;
  logic        o_tx;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int t0 = 0;
  int mon_div = 4;
  bit mon_en = 1'b0;
  logic [7:0] exp_bytes[$];

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic        exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[14];

  mmio_uart_tx dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_addr    (i_addr),
    .i_wr_data (i_wr_data),
    .i_wr_en   (i_wr_en),
    .o_rd_data (o_rd_data),
    .o_rd_sel  (o_rd_sel),
    .o_tx      (o_tx),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Expected line level at position k (1-based) inside one 10*div frame.
  function automatic logic frame_bit(input logic [7:0] b, input int k, input int div);
    int bi;
    if (k <= div) return 1'b0;
    if (k <= 9 * div) begin
      bi = (k - div - 1) / div;
      return b[bi[2:0]];
    end
    return 1'b1;
  endfunction

  task automatic check_stream();
    int rel;
    int fl;
    int f;
    int k;
    logic et;
    logic eb;
    rel = edge_cnt - t0;
    fl  = 10 * mon_div;
    et  = 1'b1;
    if (rel >= 1) begin
      f = (rel - 1) / fl;
      k = (rel - 1) % fl + 1;
      if (f < exp_bytes.size()) et = frame_bit(exp_bytes[f], k, mon_div);
    end
    eb = (rel <= exp_bytes.size() * fl);
    chk("tx_stream", 16'(o_tx), 16'(et));
    chk("busy_stream", 16'(o_busy), 16'(eb));
  endtask

  // Applies inputs at a negedge, lets one posedge consume them, returns at
  // the following negedge where outputs are stable.
  task automatic tick(input logic [15:0] a, input logic w, input logic [15:0] d, input logic r);
    i_addr = a;
    i_wr_en = w;
    i_wr_data = d;
    i_rst = r;
    @(posedge i_clk);
    edge_cnt++;
    @(negedge i_clk);
    if (mon_en) check_stream();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fifo_bytes[9];

    vecs[0]  = '{16'h0401, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[1]  = '{16'h0402, 1'b0, 16'h0000, 1'b1, 16'd868};
    vecs[2]  = '{16'h03FF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{16'h0403, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[4]  = '{16'h0403, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
    vecs[5]  = '{16'h0401, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vecs[6]  = '{16'h0402, 1'b0, 16'h0000, 1'b1, 16'd868};
    vecs[7]  = '{16'h0402, 1'b1, 16'h0001, 1'b1, 16'd868};
    vecs[8]  = '{16'h0402, 1'b0, 16'h0000, 1'b1, 16'd2};
    vecs[9]  = '{16'h0402, 1'b1, 16'h0000, 1'b1, 16'd2};
    vecs[10] = '{16'h0402, 1'b0, 16'h0000, 1'b1, 16'd2};
    vecs[11] = '{16'h0402, 1'b1, 16'h0004, 1'b1, 16'd2};
    vecs[12] = '{16'h0402, 1'b0, 16'h0000, 1'b1, 16'd4};
    vecs[13] = '{16'h0400, 1'b0, 16'h0000, 1'b1, 16'h0000};

    i_rst = 1'b1;
    i_addr = '0;
    i_wr_data = '0;
    i_wr_en = 1'b0;
    @(negedge i_clk);
    tick(16'h0000, 1'b0, 16'h0000, 1'b1);
    tick(16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("reset_tx", 16'(o_tx), 16'h0001);
    chk("reset_rd_sel", 16'(o_rd_sel), 16'h0000);
    chk("reset_rd_data", o_rd_data, 16'h0000);
    chk("reset_busy", 16'(o_busy), 16'h0000);

    // Register decode / DIV clamping table.
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0);
      chk($sformatf("vec%0d_rd_sel", i), 16'(o_rd_sel), 16'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_rd_data", i), o_rd_data, vecs[i].exp_data);
    end

    // Single frame 0xA5 at DIV=4, upper data bits ignored.
    exp_bytes.delete();
    exp_bytes.push_back(8'hA5);
    mon_div = 4;
    t0 = edge_cnt + 1;
    mon_en = 1'b1;
    tick(16'h0400, 1'b1, 16'h01A5, 1'b0);
    idle(42);
    mon_en = 1'b0;

    // FIFO fill, overflow, clear, and push coinciding with a pop at DIV=2.
    tick(16'h0402, 1'b1, 16'h0002, 1'b0);
    for (int i = 0; i < 9; i++) fifo_bytes[i] = 8'(8'h11 * (i + 1));
    exp_bytes.delete();
    for (int i = 0; i < 9; i++) exp_bytes.push_back(fifo_bytes[i]);
    exp_bytes.push_back(8'h77);
    mon_div = 2;
    t0 = edge_cnt + 1;
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) tick(16'h0400, 1'b1, {8'h00, fifo_bytes[i]}, 1'b0);
    tick(16'h0401, 1'b0, 16'h0000, 1'b0);
    chk("status_full", o_rd_data, 16'h0806);
    tick(16'h0400, 1'b1, 16'h00EE, 1'b0);
    chk("txdata_reads_zero", o_rd_data, 16'h0000);
    chk("txdata_rd_sel", 16'(o_rd_sel), 16'h0001);
    tick(16'h0401, 1'b0, 16'h0000, 1'b0);
    chk("status_overflow", o_rd_data, 16'h080E);
    tick(16'h0401, 1'b1, 16'h0000, 1'b0);
    chk("status_pre_clear", o_rd_data, 16'h080E);
    tick(16'h0401, 1'b0, 16'h0000, 1'b0);
    chk("status_cleared", o_rd_data, 16'h0806);
    idle(7);
    tick(16'h0400, 1'b1, 16'h0077, 1'b0);
    tick(16'h0401, 1'b0, 16'h0000, 1'b0);
    chk("status_push_on_pop", o_rd_data, 16'h0806);
    idle(181);
    mon_en = 1'b0;

    // Reset in the middle of the DATA state with bytes still queued.
    tick(16'h0402, 1'b1, 16'h0004, 1'b0);
    exp_bytes.delete();
    exp_bytes.push_back(8'h5A);
    mon_div = 4;
    t0 = edge_cnt + 1;
    mon_en = 1'b1;
    tick(16'h0400, 1'b1, 16'h005A, 1'b0);
    tick(16'h0400, 1'b1, 16'h0033, 1'b0);
    tick(16'h0400, 1'b1, 16'h0044, 1'b0);
    idle(17);
    mon_en = 1'b0;
    tick(16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("rst_mid_tx", 16'(o_tx), 16'h0001);
    chk("rst_mid_busy", 16'(o_busy), 16'h0000);
    tick(16'h0401, 1'b0, 16'h0000, 1'b0);
    chk("rst_mid_status_sel", 16'(o_rd_sel), 16'h0001);
    chk("rst_mid_status", o_rd_data, 16'h0001);
    tick(16'h0402, 1'b0, 16'h0000, 1'b0);
    chk("rst_mid_div", o_rd_data, 16'd868);
    for (int i = 0; i < 50; i++) begin
      tick(16'h0000, 1'b0, 16'h0000, 1'b0);
      chk("rst_mid_line_idle", 16'(o_tx), 16'h0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, at addresses just above data RAM (data RAM decodes only addresses below 1024).
- Consumes the core's o_mem_addr / o_mem_wr_data / o_mem_wr_en.
- Returns registered read data, with the same one-cycle latency as data RAM, for the top level to mux into i_mem_rd_data.
- Buffers bytes in a small FIFO and serialises them as 8N1 on o_tx.

Parameters:
- p_BASE_ADDR, 16'h0400: word address of register window (3 words: +0 TXDATA, +1 STATUS, +2 DIV).
- p_FIFO_DEPTH, 8: TX FIFO entries; power of 2, range 2..128.
- p_DIV_RESET, 16'd868: reset value of the DIV register (clock cycles per bit).

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  synchronous active-high reset.
- i_addr  in  16  bus word address (core o_mem_addr).
- i_wr_data  in  16  bus write data.
- i_wr_en  in  1  bus write strobe.
- o_rd_data  out  16  registered read data for the previous cycle's i_addr.
- o_rd_sel  out  1  registered: previous cycle's i_addr was inside the window; top muxes o_rd_data when high.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  high while FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Reset values:
  - o_tx=1, o_rd_data=0, o_rd_sel=0, o_busy=0.
  - FIFO empty; overflow flag=0; DIV=p_DIV_RESET; FSM=IDLE.
- Reset mid-frame aborts the frame immediately: o_tx=1 on the cycle after reset is sampled, and FIFO contents are discarded.
- Decode: hit = i_addr in [p_BASE_ADDR, p_BASE_ADDR+2]. Addresses outside the window are ignored. p_BASE_ADDR+3 is unmapped: reads return 0, writes are ignored.
- Writes:
  - TXDATA: push i_wr_data[7:0]; bits [15:8] ignored.
  - STATUS: any value clears the overflow flag.
  - DIV: load i_wr_data; 0 and 1 are stored as 2. The new value takes effect at the next bit boundary.
- Push acceptance:
  - A push is accepted if count < p_FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- Reads:
  - o_rd_data is registered at posedge from the current i_addr, valid the next cycle.
  - TXDATA reads as 0. DIV reads its stored value.
  - Non-hit addresses give o_rd_data=0 and o_rd_sel=0.
- STATUS layout:
  - [0] empty, [1] full, [2] FSM not IDLE, [3] overflow, [7:4]=0.
  - [15:8] FIFO count, zero-extended.
  - Sampled before any same-cycle write or pop takes effect.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..DIV-1; a bit index counts 0..7.
  - IDLE: if FIFO non-empty, pop head into the shift register and go to START. o_tx=0 from the next cycle.
  - START: after DIV cycles go to DATA with bit index 0.
  - DATA: o_tx = shift[0], LSB first; shift right every DIV cycles; after bit 7 go to STOP.
  - STOP: o_tx=1 for DIV cycles. Then, if FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Frame length: exactly 10*DIV cycles.
- Timing: a write to an empty idle block at edge N gives o_tx low from edge N+1 to edge N+1+DIV.
- o_tx is driven from a flop (no combinational path from the bus).
- FIFO pointers are log2(p_FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.

Optional Feature:
- Macro: MMIO_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for DIV cycles.
  - Frame is 11*DIV cycles.
  - STATUS[4] reads 1.
- Undefined: no PARITY state; frame is 10*DIV cycles; STATUS[4] reads 0.

Decomposition:
- Shared package/include (mmio_defs):
  - Register offsets (TXDATA=0, STATUS=1, DIV=2).
  - STATUS bit positions.
  - FSM state encodings.
  - Default base address 16'h0400.
- Sub-module: sync_fifo (parameters p_WIDTH, p_DEPTH) with push/pop, full/empty and count outputs. It is reusable by a later RX block.
- mmio_uart_tx holds decode, registers and the FSM.

Test Plan:
- Reset, then read STATUS at 0x0401: next cycle o_rd_sel=1, o_rd_data=16'h0001. Read DIV: o_rd_data=868.
- Write DIV=4, then write TXDATA=16'h1A5 at edge N: o_tx=0 over cycles N+1..N+4, then 1,0,1,0,0,1,0,1 (0xA5 LSB first, 4 cycles each), stop high 4 cycles. o_busy falls after 40 cycles.
- DIV=2, write 9 bytes back-to-back while idle: first byte pops, the next 8 fill the FIFO, no overflow. A 10th write sets STATUS[3]=1 and that byte never appears. Writing STATUS clears it.
- With FIFO full and a pop in the same cycle as a TXDATA write: the write is accepted, count stays 8, overflow stays 0.
- Read 0x03FF and 0x0403: o_rd_sel=0, o_rd_data=0. Write to 0x0403: no state change.
- Assert i_rst at the midpoint of the DATA state: o_tx=1 next cycle, STATUS reads 16'h0001, and no further frame bits appear.
